// File: rtl/dsr_align_ctrl_if.sv
// Deserializer alignment controller bus: training data and
// START in, reset, slip, status and pipeline-start outputs out.
interface dsr_align_ctrl_if #(
    parameter int NCH = 6,
    parameter int DW  = 8
);
    logic              START;
    logic [NCH*DW-1:0] DATA;
    logic              DSR_RST;
    logic [NCH-1:0]    BIT_SLIP_EVN;
    logic [NCH-1:0]    BIT_SLIP_ODD;
    logic              STRT_PIPE;
    logic [NCH-1:0]    ALIGNED;
    logic [NCH-1:0]    FAIL;
    logic              ALL_ALIGNED;
    logic              BUSY;

    modport master (
        output START, DATA,
        input  DSR_RST, BIT_SLIP_EVN, BIT_SLIP_ODD,
        input  STRT_PIPE, ALIGNED, FAIL, ALL_ALIGNED, BUSY
    );

    modport slave (
        input  START, DATA,
        output DSR_RST, BIT_SLIP_EVN, BIT_SLIP_ODD,
        output STRT_PIPE, ALIGNED, FAIL, ALL_ALIGNED, BUSY
    );
endinterface

// File: rtl/dsr_align_ctrl.sv
// Multi-channel deserializer word-alignment sequencer with bit slip.
// Define DSR_ALIGN_TMR_EN for triplicated, majority-voted state.
module dsr_align_ctrl #(
    parameter int             NCH      = 6,
    parameter int             DW       = 8,
    parameter logic [DW-1:0]  PATTERN  = DW'(8'hA5),
    parameter int             RST_CYC  = 6,
    parameter int             WAIT_CYC = 5
) (
    input logic             CLK,
    input logic             RST_B,
    dsr_align_ctrl_if.slave bus
);
    localparam int MAXC = (RST_CYC > WAIT_CYC) ? RST_CYC : WAIT_CYC;
    localparam int WW   = $clog2(MAXC + 1);
    localparam int SW   = $clog2(DW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DSR_RST,
        S_WRST,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_RESTART,
        S_DONE
    } state_t;

    // Every register lives in this bundle so the TMR build votes it as one.
    typedef struct packed {
        state_t         state;
        logic [WW-1:0]  wcnt;
        logic [SW-1:0]  scnt;
        logic [NCH-1:0] aligned;
        logic [NCH-1:0] fail;
        logic           dsr_rst;
        logic [NCH-1:0] evn;
        logic [NCH-1:0] odd;
        logic           strt;
        logic           all_al;
        logic           busy;
    } ctl_t;

    ctl_t           w_q;
    ctl_t           w_d;
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_mask;

    always_comb begin
        w_d    = w_q;
        w_hit  = '0;
        w_mask = '0;
        unique case (w_q.state)
            S_IDLE: begin
                w_d.state = S_DSR_RST;
                w_d.wcnt  = '0;
            end
            S_DSR_RST: begin
                if (w_q.wcnt == WW'(RST_CYC - 1)) begin
                    w_d.state = S_WRST;
                    w_d.wcnt  = '0;
                end else begin
                    w_d.wcnt = w_q.wcnt + WW'(1);
                end
            end
            S_WRST: begin
                w_d.state = S_SETTLE;
                w_d.wcnt  = '0;
            end
            S_SETTLE: begin
                if (w_q.wcnt == WW'(WAIT_CYC - 1)) begin
                    w_d.state = S_CHECK;
                    w_d.wcnt  = '0;
                end else begin
                    w_d.wcnt = w_q.wcnt + WW'(1);
                end
            end
            S_CHECK: begin
                for (int n = 0; n < NCH; n++) begin
                    w_hit[n] = !w_q.aligned[n] && !w_q.fail[n]
                            && (bus.DATA[n*DW +: DW] == PATTERN);
                end
                w_d.aligned = w_q.aligned | w_hit;
                if (&(w_d.aligned | w_q.fail)) begin
                    w_d.state = S_RESTART;
                end else if (w_q.scnt < SW'(DW)) begin
                    w_d.state = S_SLIP;
                end else begin
                    w_d.fail  = w_q.fail | ~w_d.aligned;
                    w_d.state = S_RESTART;
                end
            end
            S_SLIP: begin
                w_d.scnt  = w_q.scnt + SW'(1);
                w_d.state = S_SETTLE;
                w_d.wcnt  = '0;
            end
            S_RESTART: w_d.state = S_DONE;
            S_DONE:    w_d.state = S_DONE;
        endcase

        if (bus.START && (w_q.state != S_IDLE)) begin
            w_d.state   = S_DSR_RST;
            w_d.wcnt    = '0;
            w_d.scnt    = '0;
            w_d.aligned = '0;
            w_d.fail    = '0;
        end

        // Outputs are decoded from the next state so they align with it.
        w_d.dsr_rst = (w_d.state == S_DSR_RST);
        w_d.evn     = '0;
        w_d.odd     = '0;
        if (w_d.state == S_SLIP) begin
            w_mask  = ~(w_d.aligned | w_d.fail);
            w_d.odd = w_mask;
            w_d.evn = (w_d.scnt == SW'(DW / 2)) ? '0 : w_mask;
        end
        w_d.strt   = (w_d.state == S_RESTART);
        w_d.busy   = (w_d.state != S_DONE);
        w_d.all_al = (w_d.state == S_DONE) && (&w_d.aligned);
    end

`ifdef DSR_ALIGN_TMR_EN
    ctl_t r_q0;
    ctl_t r_q1;
    ctl_t r_q2;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_q0      <= '0;
            r_q1      <= '0;
            r_q2      <= '0;
            r_q0.busy <= 1'b1;
            r_q1.busy <= 1'b1;
            r_q2.busy <= 1'b1;
        end else begin
            r_q0 <= w_d;
            r_q1 <= w_d;
            r_q2 <= w_d;
        end
    end

    assign w_q = ctl_t'((r_q0 & r_q1) | (r_q1 & r_q2) | (r_q0 & r_q2));
`else
    ctl_t r_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_q      <= '0;
            r_q.busy <= 1'b1;
        end else begin
            r_q <= w_d;
        end
    end

    assign w_q = r_q;
`endif

    assign bus.DSR_RST      = w_q.dsr_rst;
    assign bus.BIT_SLIP_EVN = w_q.evn;
    assign bus.BIT_SLIP_ODD = w_q.odd;
    assign bus.STRT_PIPE    = w_q.strt;
    assign bus.ALIGNED      = w_q.aligned;
    assign bus.FAIL         = w_q.fail;
    assign bus.ALL_ALIGNED  = w_q.all_al;
    assign bus.BUSY         = w_q.busy;
endmodule

// File: doc/dsr_align_ctrl.md
DSR_ALIGN_CTRL -- requirements
Module: dsr_align_ctrl

Interface
REQ-001 Parameter NCH, default 6: number of deserializer channels aligned in parallel.
REQ-002 Parameter DW, default 8: deserialized word width per channel; even, 4 to 16.
REQ-003 Parameter PATTERN, default 8'hA5 (DW bits): training word each channel must present when aligned.
REQ-004 Parameter RST_CYC, default 6: cycles DSR_RST is held high.
REQ-005 Parameter WAIT_CYC, default 5: settle cycles after DSR reset release and after every slip.
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RST_B  in  1  reset, asynchronous assert, active-low.
REQ-008 START  in  1  synchronous one-cycle request to restart full alignment.
REQ-009 DATA  in  NCH*DW  deserialized words; channel n occupies bits [n*DW+DW-1 : n*DW].
REQ-010 DSR_RST  out  1  deserializer reset.
REQ-011 BIT_SLIP_EVN  out  NCH  per-channel even-phase slip pulse.
REQ-012 BIT_SLIP_ODD  out  NCH  per-channel odd-phase slip pulse.
REQ-013 STRT_PIPE  out  1  one-cycle pipeline start pulse.
REQ-014 ALIGNED  out  NCH  per-channel sticky aligned flag.
REQ-015 FAIL  out  NCH  per-channel sticky alignment-failure flag.
REQ-016 ALL_ALIGNED  out  1  high when ALIGNED is all ones and sequencer is in DONE.
REQ-017 BUSY  out  1  high in every state except DONE.

Function
REQ-018 States SHALL be IDLE, DSR_RST, WRST, SETTLE, CHECK, SLIP, RESTART, DONE.
REQ-019 IDLE -> DSR_RST unconditionally, one cycle after reset release.
REQ-020 DSR_RST held exactly RST_CYC cycles, DSR_RST output high throughout, then WRST for one cycle, then SETTLE.
REQ-021 SETTLE lasts exactly WAIT_CYC cycles, then CHECK for one cycle.
REQ-022 In CHECK, each channel not ALIGNED and not FAIL whose DATA word equals PATTERN SHALL set its ALIGNED bit.
REQ-023 CHECK -> RESTART if every channel is ALIGNED or FAIL after the update; else CHECK -> SLIP if slip_cnt < DW; else set FAIL for all still-unaligned channels and go to RESTART.
REQ-024 SLIP lasts one cycle: pulse slip outputs only for channels neither ALIGNED nor FAIL; slip_cnt increments; then SETTLE.
REQ-025 Slip phase: pre-increment slip_cnt == DW/2 SHALL assert BIT_SLIP_ODD only; any other value SHALL assert both EVN and ODD.
REQ-026 RESTART asserts STRT_PIPE for exactly one cycle, then DONE; DONE holds indefinitely.
REQ-027 START in any state except IDLE forces DSR_RST next cycle and clears ALIGNED, FAIL, slip_cnt and wait counter; START overrides a same-cycle CHECK update.
REQ-028 slip_cnt width clog2(DW+1), never wraps; wait counter wide enough for max(RST_CYC, WAIT_CYC) without wrap.
REQ-029 All outputs SHALL be registered, decoded from next state, so each assertion coincides with the matching state.
REQ-030 ALIGNED and FAIL are never both high for one channel.

Reset
REQ-031 RST_B low immediately forces state IDLE, all counters 0, all outputs 0, BUSY 1 (IDLE), regardless of state.
REQ-032 Reset mid-slip SHALL drop any BIT_SLIP pulse in the same instant; no partial pulse after release.

Configuration
REQ-033 Macro DSR_ALIGN_TMR_EN: when defined, state, counters, ALIGNED, FAIL and all output registers SHALL be triplicated with 2-of-3 majority voting on feedback and outputs; when undefined, a single copy; cycle behaviour identical in both builds.

Verification (NCH=4, DW=8, PATTERN=8'hA5, RST_CYC=6, WAIT_CYC=5)
REQ-034 Release reset, all channels present A5 -> DSR_RST high 6 cycles, no slip pulses, one STRT_PIPE pulse, ALIGNED=4'hF, ALL_ALIGNED=1, BUSY=0.
REQ-035 Channel 2 shows A5 only after 3 slips -> exactly 3 EVN+ODD pulses on bit 2, none on other bits, ALIGNED[2] set at fourth CHECK.
REQ-036 Channel 1 aligns after 5 slips -> fifth slip (slip_cnt 4) pulses BIT_SLIP_ODD[1] only, BIT_SLIP_EVN[1]=0.
REQ-037 Channel 3 never shows A5 -> 8 slips on bit 3, FAIL=4'h8, ALIGNED=4'h7, ALL_ALIGNED=0, one STRT_PIPE pulse.
REQ-038 START pulsed in SETTLE after 2 slips -> DSR_RST high next cycle, ALIGNED=0, FAIL=0, slip sequence restarts from slip_cnt 0.
REQ-039 RST_B low during a SLIP cycle -> all outputs 0 asynchronously; after release sequence restarts from IDLE; repeat with DSR_ALIGN_TMR_EN defined and an injected single-copy state upset -> no output change.
